// File: rtl/io_defs.sv
// Shared widths and I/O address map for the cpu memory-bus bridge.
package io_defs;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CPU_ADDR_W = 32;
  localparam int unsigned DEC_W = 18;
  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] IO_SEL = 2'b11;
  localparam logic [DEC_W-1:0] IO_UART = 18'h30000;
  localparam logic [DEC_W-1:0] IO_CLK  = 18'h30004;
endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with full/empty flags; overflow pushes and
// underflow pops are ignored.
module sync_fifo
  import io_defs::*;
#(
  parameter int unsigned DEPTH_LOG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam int unsigned FILL_W = DEPTH_LOG + 1;

  logic [BYTE_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [FILL_W-1:0]    fill;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (fill == FILL_W'(DEPTH));
  assign empty   = (fill == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage needs no reset; only pointers and fill level define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG'(1);
      case ({do_push, do_pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end
endmodule

// File: rtl/io_bridge.sv
// Steers cpu byte accesses to RAM or the I/O window, owns the UART FIFOs,
// cycle counter and program-stop latch, and generates the cpu ready signal.
module io_bridge
  import io_defs::*;
#(
  parameter int unsigned RAM_ADDR_W   = 17,
  parameter int unsigned RX_DEPTH_LOG = 4,
  parameter int unsigned TX_DEPTH_LOG = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [CPU_ADDR_W-1:0] cpu_a,
  input  logic                  cpu_wr,
  input  logic [BYTE_W-1:0]     cpu_dout,
  output logic [BYTE_W-1:0]     cpu_din,
  output logic                  cpu_rdy,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_wr,
  output logic [BYTE_W-1:0]     ram_dout,
  input  logic [BYTE_W-1:0]     ram_din,
  input  logic                  rx_valid,
  input  logic [BYTE_W-1:0]     rx_data,
  output logic                  rx_ready,
  output logic                  tx_valid,
  output logic [BYTE_W-1:0]     tx_data,
  input  logic                  tx_ready,
  output logic                  prog_stop
);
  logic [DEC_W-1:0]  dec_a;
  logic              io_sel;
  logic              is_uart;
  logic              is_clk;
  logic              is_snap_hi;
  logic              rd_uart;
  logic              tx_need;
  logic              fire;
  logic              unused_a_hi;

  logic              rx_full, rx_empty;
  logic [BYTE_W-1:0] rx_head;
  logic              tx_full, tx_empty;
  logic [BYTE_W-1:0] tx_push_data;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  snap;
  logic              halted;
  logic              src_q;
  logic [BYTE_W-1:0] io_byte_q;
  logic              fired_q;
  logic [BYTE_W-1:0] last_din_q;
  logic [BYTE_W-1:0] io_rd_byte;

  assign dec_a       = cpu_a[DEC_W-1:0];
  assign unused_a_hi = ^cpu_a[CPU_ADDR_W-1:DEC_W];
  assign io_sel      = (dec_a[DEC_W-1:DEC_W-2] == IO_SEL);
  assign is_uart     = (dec_a == IO_UART);
  assign is_clk      = (dec_a == IO_CLK);
  assign is_snap_hi  = (dec_a[DEC_W-1:2] == IO_CLK[DEC_W-1:2]) && (dec_a[1:0] != 2'b00);

  assign ram_a    = cpu_a[RAM_ADDR_W-1:0];
  assign ram_dout = cpu_dout;
  assign ram_wr   = cpu_wr & ~io_sel & cpu_rdy;

  // A zero byte to the UART port is dropped, so only nonzero data needs TX room.
  assign rd_uart = ~cpu_wr & is_uart;
  assign tx_need = cpu_wr & ((is_uart & (cpu_dout != '0)) | is_clk);
  assign cpu_rdy = ~rst_in & ~halted & ~(rd_uart & rx_empty) & ~(tx_need & tx_full);
  assign fire    = cpu_rdy;

  assign rx_ready     = ~rx_full & ~rst_in;
  assign tx_valid     = ~tx_empty;
  assign tx_push_data = is_clk ? '0 : cpu_dout;

  sync_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (rx_valid & rx_ready),
    .pop   (fire & rd_uart),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (fire & tx_need),
    .pop   (tx_valid & tx_ready),
    .din   (tx_push_data),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Byte returned by an I/O read; the 0x30004 read shows the live counter.
  always_comb begin
    io_rd_byte = '0;
    if (is_uart) begin
      io_rd_byte = rx_head;
    end else if (is_clk) begin
      io_rd_byte = cnt[7:0];
    end else if (is_snap_hi) begin
      case (dec_a[1:0])
        2'b01:   io_rd_byte = snap[15:8];
        2'b10:   io_rd_byte = snap[23:16];
        default: io_rd_byte = snap[31:24];
      endcase
    end
  end

  // While frozen the cpu sees the last returned byte, not a fresh RAM read.
  assign cpu_din = fired_q ? (src_q ? io_byte_q : ram_din) : last_din_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt        <= '0;
      snap       <= '0;
      halted     <= 1'b0;
      prog_stop  <= 1'b0;
      src_q      <= 1'b0;
      io_byte_q  <= '0;
      fired_q    <= 1'b0;
      last_din_q <= '0;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      prog_stop  <= 1'b0;
      fired_q    <= fire;
      last_din_q <= cpu_din;
      if (fire) begin
        src_q     <= io_sel;
        io_byte_q <= cpu_wr ? '0 : io_rd_byte;
        if (~cpu_wr & is_clk) snap <= cnt;
        if (cpu_wr & is_clk) begin
          halted    <= 1'b1;
          prog_stop <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: directed tables/sequences plus random
// traffic against a queue-based reference model.
module tb_io_bridge;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] cpu_a = '0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [16:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        prog_stop;

  io_bridge dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .prog_stop(prog_stop)
  );

  always #5 clk_in = ~clk_in;

  // External 128KB RAM with one-cycle read latency
  logic [7:0] ram_mem [0:131071];
  always @(posedge clk_in) begin
    if (ram_wr) ram_mem[ram_a] <= ram_dout;
    ram_din <= ram_mem[ram_a];
  end

  int errs = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  m_rx[$];
  logic [7:0]  m_tx[$];
  logic [7:0]  m_mem [int];
  logic [31:0] m_cnt = '0;
  logic [31:0] m_snap = '0;
  logic        m_halt = 1'b0;
  logic        m_ps = 1'b0;
  logic [7:0]  m_din = '0;
  logic        m_din_ok = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_rdy = 1'b0;

  // Samples of the most recent step
  logic        s_rdy, s_ps, s_txv;
  logic [7:0]  s_din, s_txd;
  int          ramwr_cnt = 0;
  logic [7:0]  tx_seen[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input int k);
    return m_mem.exists(k) ? m_mem[k] : 8'h00;
  endfunction

  task automatic step(input logic [31:0] a, input logic w, input logic [7:0] d,
                      input logic rst, input logic rv, input logic [7:0] rd,
                      input logic tr);
    logic [17:0] a18;
    logic        io, need_tx, e_rdy, e_rxr;
    logic [7:0]  nd;
    cpu_a = a; cpu_wr = w; cpu_dout = d; rst_in = rst;
    rx_valid = rv; rx_data = rd; tx_ready = tr;
    a18 = a[17:0];
    io = (a18[17:16] == 2'b11);
    need_tx = w && ((a18 == 18'h30000 && d != 8'h00) || a18 == 18'h30004);
    e_rdy = !rst && !m_halt && !(!w && a18 == 18'h30000 && m_rx.size() == 0)
            && !(need_tx && m_tx.size() == 16);
    e_rxr = !rst && m_rx.size() < 16;
    m_rdy = e_rdy;
    #1;
    s_rdy = cpu_rdy; s_din = cpu_din; s_ps = prog_stop; s_txv = tx_valid; s_txd = tx_data;
    if (ram_wr) ramwr_cnt++;
    if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
    if (m_valid) begin
      chk("cpu_rdy", 32'(cpu_rdy), 32'(e_rdy));
      chk("ram_wr", 32'(ram_wr), 32'(w && !io && e_rdy));
      chk("ram_a", 32'(ram_a), 32'(a[16:0]));
      chk("rx_ready", 32'(rx_ready), 32'(e_rxr));
      chk("tx_valid", 32'(tx_valid), 32'(m_tx.size() > 0));
      if (m_tx.size() > 0) chk("tx_data", 32'(tx_data), 32'(m_tx[0]));
      chk("prog_stop", 32'(prog_stop), 32'(m_ps));
      if (m_din_ok) chk("cpu_din", 32'(cpu_din), 32'(m_din));
    end
    @(posedge clk_in);
    if (rst) begin
      m_rx.delete(); m_tx.delete();
      m_cnt = '0; m_snap = '0; m_halt = 1'b0; m_ps = 1'b0;
      m_din = '0; m_din_ok = 1'b1; m_valid = 1'b1;
    end else begin
      m_ps = 1'b0;
      if (m_tx.size() > 0 && tr) void'(m_tx.pop_front());
      if (e_rdy) begin
        if (!w) begin
          nd = 8'h00;
          if (!io) nd = mem_rd(int'(a[16:0]));
          else if (a18 == 18'h30000) nd = m_rx.pop_front();
          else if (a18 == 18'h30004) begin m_snap = m_cnt; nd = m_cnt[7:0]; end
          else if (a18 == 18'h30005) nd = m_snap[15:8];
          else if (a18 == 18'h30006) nd = m_snap[23:16];
          else if (a18 == 18'h30007) nd = m_snap[31:24];
          m_din = nd; m_din_ok = 1'b1;
        end else begin
          m_din_ok = 1'b0;
          if (!io) m_mem[int'(a[16:0])] = d;
          else if (a18 == 18'h30000 && d != 8'h00) m_tx.push_back(d);
          else if (a18 == 18'h30004) begin m_tx.push_back(8'h00); m_halt = 1'b1; m_ps = 1'b1; end
        end
      end
      if (rv && e_rxr) m_rx.push_back(rd);
      m_cnt = m_cnt + 32'd1;
    end
    @(negedge clk_in);
  endtask

  task automatic idle(input logic tr);
    step(32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, tr);
  endtask

  task automatic do_reset();
    step(32'h0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_rdy", 32'(s_rdy), 32'h0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [7:0]  d;
    logic        rdy;
    logic        cd;
    logic [7:0]  din;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] ra, t;
    logic        rw, hold;
    logic [7:0]  rdat;
    for (int i = 0; i < 131072; i++) ram_mem[i] = 8'h00;

    // Table: counter snapshot on cycles 10-13, then RAM write/read
    for (int i = 0; i < 10; i++) tbl.push_back('{32'h0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{32'h30004, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{32'h30005, 1'b0, 8'h00, 1'b1, 1'b1, 8'h0A});
    tbl.push_back('{32'h30006, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00});
    tbl.push_back('{32'h30007, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00});
    tbl.push_back('{32'h00000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00});
    tbl.push_back('{32'h00010, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{32'h00010, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{32'h00000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A});
    tbl.push_back('{32'h30008, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{32'h00000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00});

    @(negedge clk_in);
    do_reset();
    ramwr_cnt = 0;
    foreach (tbl[i]) begin
      step(tbl[i].a, tbl[i].w, tbl[i].d, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("tbl_rdy", 32'(s_rdy), 32'(tbl[i].rdy));
      if (tbl[i].cd) chk("tbl_din", 32'(s_din), 32'(tbl[i].din));
    end
    chk("ram_wr_pulses", 32'(ramwr_cnt), 32'd1);

    // Counter wrap
    @(negedge clk_in);
    force dut.cnt = 32'hFFFF_FFFF;
    #1 release dut.cnt;
    m_cnt = 32'hFFFF_FFFF;
    step(32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    step(32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("wrap_ff", 32'(s_din), 32'hFF);
    step(32'h30007, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("wrap_zero", 32'(s_din), 32'h00);
    idle(1'b0);
    chk("wrap_hi", 32'(s_din), 32'h00);

    // RX stall then reset mid-stall
    do_reset();
    for (int i = 0; i < 5; i++) step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rx_stall", 32'(s_rdy), 32'h0);
    step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 1'b0);
    chk("rx_stall_c5", 32'(s_rdy), 32'h0);
    step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rx_go_c6", 32'(s_rdy), 32'h1);
    step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rx_din_c7", 32'(s_din), 32'h41);
    chk("rx_empty_again", 32'(s_rdy), 32'h0);
    step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    step(32'h30000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_stall_din", 32'(s_din), 32'h00);
    chk("rst_stall_rdy", 32'(s_rdy), 32'h0);
    step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0);
    step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rx_after_rst_rdy", 32'(s_rdy), 32'h1);
    idle(1'b0);
    chk("rx_after_rst_din", 32'(s_din), 32'h33);

    // TX: zero writes dropped
    do_reset();
    tx_seen.delete();
    step(32'h30000, 1'b1, 8'h48, 1'b0, 1'b0, 8'h00, 1'b0);
    step(32'h30000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("tx_zero_nostall", 32'(s_rdy), 32'h1);
    step(32'h30000, 1'b1, 8'h69, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("tx_stream_len", 32'(tx_seen.size()), 32'd2);
    if (tx_seen.size() == 2) begin
      chk("tx_stream0", 32'(tx_seen[0]), 32'h48);
      chk("tx_stream1", 32'(tx_seen[1]), 32'h69);
    end

    // TX full: 17th write stalls until one pop
    tx_seen.delete();
    for (int i = 0; i < 16; i++) begin
      step(32'h30000, 1'b1, 8'(i + 1), 1'b0, 1'b0, 8'h00, 1'b0);
      chk("tx_fill_rdy", 32'(s_rdy), 32'h1);
    end
    for (int i = 0; i < 3; i++) begin
      step(32'h30000, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("tx_full_stall", 32'(s_rdy), 32'h0);
    end
    step(32'h30000, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("tx_full_prepop", 32'(s_rdy), 32'h0);
    step(32'h30000, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("tx_full_release", 32'(s_rdy), 32'h1);
    for (int i = 0; i < 20; i++) idle(1'b1);
    chk("tx_drain_len", 32'(tx_seen.size()), 32'd17);
    if (tx_seen.size() == 17) chk("tx_drain_last", 32'(tx_seen[16]), 32'h77);

    // Program stop
    do_reset();
    step(32'h30004, 1'b1, 8'hAB, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("stop_fire", 32'(s_rdy), 32'h1);
    idle(1'b0);
    chk("stop_pulse", 32'(s_ps), 32'h1);
    chk("stop_tx_valid", 32'(s_txv), 32'h1);
    chk("stop_tx_zero", 32'(s_txd), 32'h00);
    chk("stop_frozen", 32'(s_rdy), 32'h0);
    idle(1'b1);
    chk("stop_pulse_end", 32'(s_ps), 32'h0);
    step(32'h00020, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("stop_still_frozen", 32'(s_rdy), 32'h0);
    chk("stop_tx_drained", 32'(s_txv), 32'h0);
    do_reset();
    idle(1'b0);
    chk("stop_rst_release", 32'(s_rdy), 32'h1);

    // Random traffic against the model
    do_reset();
    hold = 1'b0;
    ra = '0; rw = 1'b0; rdat = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        t = $urandom();
        case ($urandom_range(0, 9))
          0, 1, 2: ra = 32'(t[5:0]);
          3:       ra = {t[31:18], 12'h000, t[5:0]};
          4, 5:    ra = 32'h30000;
          6:       ra = 32'h30004;
          7:       ra = 32'h30000 + 32'($urandom_range(5, 7));
          8:       ra = 32'h30008 + 32'(t[7:0]);
          default: ra = 32'h20000 + 32'(t[5:0]);
        endcase
        rw = 1'($urandom_range(0, 1));
        rdat = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
        if (ra[17:0] == 18'h30004) rw = 1'b0;
      end
      step(ra, rw, rdat, 1'b0, 1'($urandom_range(0, 2) == 0), 8'($urandom()),
           1'($urandom_range(0, 1)));
      hold = !m_rdy;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
